// File: rtl/fwd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fwd_pkg : shared constants and types for the forwarding / hazard block  rev 1.0
// ---------------------------------------------------------------------------
package fwd_pkg;

  localparam int REG_AW      = 5;
  localparam int FWD_SEL_REG = 0;
  localparam int FWD_SEL_MEM = 1;
  localparam int FWD_SEL_WB  = 2;

  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage
`default_nettype wire

// File: rtl/fwd_sel_enc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fwd_sel_enc : per-operand priority encoder over the forwarding stages  rev 1.0
// ---------------------------------------------------------------------------
module fwd_sel_enc
  import fwd_pkg::*;
#(
  parameter int NUM_FWD_STAGES = 2,
  parameter int ADDR_W         = 5,
  parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic [ADDR_W-1:0]                rs,
  input  logic [NUM_FWD_STAGES*ADDR_W-1:0] stg_rd,
  input  logic [NUM_FWD_STAGES-1:0]        stg_we,
  output logic [SEL_W-1:0]                 sel
);

  // Scan oldest to youngest so the youngest matching stage overwrites last.
  always_comb begin
    sel = SEL_W'(FWD_SEL_REG);
    for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
      if (stg_we[k] &&
          (stg_rd[k*ADDR_W +: ADDR_W] != '0) &&
          (stg_rd[k*ADDR_W +: ADDR_W] == rs)) begin
        sel = SEL_W'(k + 1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fwd_hazard_scoreboard : EX/ID bypass selects plus latency scoreboard stall  rev 1.0
// ---------------------------------------------------------------------------
module fwd_hazard_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int REG_AW         = fwd_pkg::REG_AW,
  parameter int MAX_LAT        = 15,
  parameter int CNT_W          = $clog2(MAX_LAT + 1),
  parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]        id_rs,
  input  logic [NUM_SRC-1:0]               id_rs_used,
  input  logic [REG_AW-1:0]                id_rd,
  input  logic                             id_we,
  input  logic [CNT_W-1:0]                 id_lat,
  input  logic                             flush,
  input  logic [NUM_SRC*REG_AW-1:0]        ex_rs,
  input  logic [NUM_FWD_STAGES*REG_AW-1:0] stg_rd,
  input  logic [NUM_FWD_STAGES-1:0]        stg_we,
  output logic [NUM_SRC*SEL_W-1:0]         fwd_ex_sel,
  output logic [NUM_SRC-1:0]               fwd_id_sel,
  output logic                             stall,
  output logic                             any_pending,
  output logic [31:0]                      stall_cnt
);

  localparam int NUM_REGS = 1 << REG_AW;
  localparam int WB_IDX   = NUM_FWD_STAGES - 1;

  logic [CNT_W-1:0] pend [NUM_REGS];
  logic [31:0]      stall_cnt_q;
  logic [CNT_W-1:0] lat_clamped;
  logic             stall_hit;
  logic             issue;
  logic             wr_en;

  genvar s;
  generate
    for (s = 0; s < NUM_SRC; s++) begin : g_src
      fwd_sel_enc #(
        .NUM_FWD_STAGES (NUM_FWD_STAGES),
        .ADDR_W         (REG_AW),
        .SEL_W          (SEL_W)
      ) u_enc (
        .rs     (ex_rs[s*REG_AW +: REG_AW]),
        .stg_rd (stg_rd),
        .stg_we (stg_we),
        .sel    (fwd_ex_sel[s*SEL_W +: SEL_W])
      );

      // x0 is never bypassed: a WB "write" to x0 carries no real value.
      assign fwd_id_sel[s] = stg_we[WB_IDX] &
                             (stg_rd[WB_IDX*REG_AW +: REG_AW] != '0) &
                             (stg_rd[WB_IDX*REG_AW +: REG_AW] == id_rs[s*REG_AW +: REG_AW]);
    end
  endgenerate

  always_comb begin
    lat_clamped = id_lat;
    if (id_lat > CNT_W'(MAX_LAT)) lat_clamped = CNT_W'(MAX_LAT);
  end

  // A count of 1 means the value is forwardable from MEM next cycle, so only >1 stalls.
  always_comb begin
    stall_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i] &&
          (id_rs[i*REG_AW +: REG_AW] != '0) &&
          (pend[id_rs[i*REG_AW +: REG_AW]] > CNT_W'(1))) begin
        stall_hit = 1'b1;
      end
    end
  end

  assign stall = id_valid & ~flush & stall_hit;
  assign issue = id_valid & ~stall & ~flush;
  assign wr_en = issue & id_we & (id_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (r == 0) begin
          pend[r] <= '0;
        end else if (wr_en && (id_rd == REG_AW'(r))) begin
          pend[r] <= lat_clamped;
        end else if (pend[r] != '0) begin
          pend[r] <= pend[r] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    any_pending = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (pend[r] != '0) any_pending = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fwd_hazard_scoreboard : directed vectors, queued expectations, negedge monitor  rev 1.0
// ---------------------------------------------------------------------------
module tb_fwd_hazard_scoreboard;

  localparam logic [4:0] EN_EX = 5'b00001;
  localparam logic [4:0] EN_ID = 5'b00010;
  localparam logic [4:0] EN_ST = 5'b00100;
  localparam logic [4:0] EN_AP = 5'b01000;
  localparam logic [4:0] EN_CN = 5'b10000;
  localparam logic [4:0] ALL   = 5'b11111;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  id_rd;
  logic        id_we;
  logic [3:0]  id_lat;
  logic        flush;
  logic [9:0]  ex_rs;
  logic [9:0]  stg_rd;
  logic [1:0]  stg_we;
  logic [3:0]  fwd_ex_sel;
  logic [1:0]  fwd_id_sel;
  logic        stall;
  logic        any_pending;
  logic [31:0] stall_cnt;

  typedef struct {
    string       name;
    logic [3:0]  ex;
    logic [1:0]  idb;
    logic        st;
    logic        ap;
    logic [31:0] cnt;
    logic [4:0]  en;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  fwd_hazard_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rs_used  (id_rs_used),
    .id_rd       (id_rd),
    .id_we       (id_we),
    .id_lat      (id_lat),
    .flush       (flush),
    .ex_rs       (ex_rs),
    .stg_rd      (stg_rd),
    .stg_we      (stg_we),
    .fwd_ex_sel  (fwd_ex_sel),
    .fwd_id_sel  (fwd_id_sel),
    .stall       (stall),
    .any_pending (any_pending),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      if (mon_e.en[0]) begin
        checks++;
        if (fwd_ex_sel !== mon_e.ex) begin
          failures++;
          $display("FAIL %s fwd_ex_sel got=%h exp=%h", mon_e.name, fwd_ex_sel, mon_e.ex);
        end
      end
      if (mon_e.en[1]) begin
        checks++;
        if (fwd_id_sel !== mon_e.idb) begin
          failures++;
          $display("FAIL %s fwd_id_sel got=%b exp=%b", mon_e.name, fwd_id_sel, mon_e.idb);
        end
      end
      if (mon_e.en[2]) begin
        checks++;
        if (stall !== mon_e.st) begin
          failures++;
          $display("FAIL %s stall got=%b exp=%b", mon_e.name, stall, mon_e.st);
        end
      end
      if (mon_e.en[3]) begin
        checks++;
        if (any_pending !== mon_e.ap) begin
          failures++;
          $display("FAIL %s any_pending got=%b exp=%b", mon_e.name, any_pending, mon_e.ap);
        end
      end
      if (mon_e.en[4]) begin
        checks++;
        if (stall_cnt !== mon_e.cnt) begin
          failures++;
          $display("FAIL %s stall_cnt got=%h exp=%h", mon_e.name, stall_cnt, mon_e.cnt);
        end
      end
    end
  end

  // Queue the expectation for the current cycle, then advance to just after the next edge.
  task automatic chk(input string name, input logic [4:0] en, input logic [3:0] ex,
                     input logic [1:0] idb, input logic st, input logic ap,
                     input logic [31:0] cnt);
    exp_t e;
    e.name = name; e.en = en; e.ex = ex; e.idb = idb;
    e.st = st; e.ap = ap; e.cnt = cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [1:0] used, input logic [4:0] rd, input logic we,
                        input logic [3:0] lat, input logic fl);
    id_valid   = v;
    id_rs      = {r1, r0};
    id_rs_used = used;
    id_rd      = rd;
    id_we      = we;
    id_lat     = lat;
    flush      = fl;
  endtask

  task automatic set_stg(input logic [1:0] we, input logic [4:0] rd0, input logic [4:0] rd1);
    stg_we = we;
    stg_rd = {rd1, rd0};
  endtask

  task automatic set_ex(input logic [4:0] r0, input logic [4:0] r1);
    ex_rs = {r1, r0};
  endtask

  initial begin
    rst_n = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_stg(2'b00, 0, 0);
    set_ex(0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("reset", ALL, 4'h0, 2'b00, 0, 0, 0);

    // Combinational forwarding
    set_stg(2'b01, 5, 0); set_ex(5, 0);
    chk("alu_fwd", ALL, 4'b0001, 2'b00, 0, 0, 0);
    set_stg(2'b11, 7, 7); set_ex(0, 7); id_rs = {5'd0, 5'd7};
    chk("mem_prio", EN_EX | EN_ID, 4'b0100, 2'b01, 0, 0, 0);
    set_stg(2'b10, 0, 7); set_ex(0, 7);
    chk("wb_only", EN_EX | EN_ID, 4'b1000, 2'b01, 0, 0, 0);
    set_stg(2'b11, 0, 0); set_ex(0, 0); id_rs = '0;
    chk("x0_nofwd", EN_EX | EN_ID, 4'b0000, 2'b00, 0, 0, 0);
    set_stg(2'b00, 0, 0);

    // Load-use, latency 2
    set_id(1, 0, 0, 2'b00, 5, 1, 2, 0);
    chk("ld_issue", ALL, 0, 0, 0, 0, 0);
    set_id(1, 5, 0, 2'b01, 0, 0, 0, 0);
    chk("ld_use_stall", ALL, 0, 0, 1, 1, 0);
    chk("ld_use_go", ALL, 0, 0, 0, 1, 1);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_stg(2'b01, 5, 0); set_ex(5, 0);
    chk("ld_use_ex", ALL, 4'b0001, 0, 0, 0, 1);
    set_stg(2'b00, 0, 0); set_ex(0, 0);

    // Divide, latency 10; first attempt flushed
    set_id(1, 0, 0, 2'b00, 9, 1, 10, 1);
    chk("div_flush", ALL, 0, 0, 0, 0, 1);
    set_id(1, 0, 0, 2'b00, 9, 1, 10, 0);
    chk("div_issue", ALL, 0, 0, 0, 0, 1);
    set_id(1, 9, 0, 2'b01, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) chk("div_stall", ALL, 0, 0, 1, 1, 32'(1 + i));
    chk("div_go", ALL, 0, 0, 0, 1, 10);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    chk("div_done", ALL, 0, 0, 0, 0, 10);

    // WAW: short producer replaces long one
    set_id(1, 0, 0, 2'b00, 3, 1, 10, 0);
    chk("waw_long", ALL, 0, 0, 0, 0, 10);
    set_id(1, 0, 0, 2'b00, 3, 1, 1, 0);
    chk("waw_short", ALL, 0, 0, 0, 1, 10);
    set_id(1, 3, 0, 2'b01, 0, 0, 0, 0);
    chk("waw_reader", ALL, 0, 0, 0, 1, 10);

    // Flush masks a pending stall; counters keep draining
    set_id(1, 0, 0, 2'b00, 6, 1, 4, 0);
    chk("fl_issue", ALL, 0, 0, 0, 0, 10);
    set_id(1, 0, 6, 2'b10, 0, 0, 0, 1);
    chk("fl_mask", ALL, 0, 0, 0, 1, 10);
    set_id(1, 0, 6, 2'b10, 0, 0, 0, 0);
    chk("fl_stall3", ALL, 0, 0, 1, 1, 10);
    chk("fl_stall2", ALL, 0, 0, 1, 1, 11);
    chk("fl_go", ALL, 0, 0, 0, 1, 12);

    // Asynchronous reset with pend[4] == 6
    set_id(1, 0, 0, 2'b00, 4, 1, 7, 0);
    chk("rst_issue", ALL, 0, 0, 0, 0, 12);
    set_id(1, 4, 0, 2'b01, 0, 0, 0, 0);
    chk("rst_pre", ALL, 0, 0, 1, 1, 12);
    rst_n = 1'b0;
    chk("async_rst", ALL, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    chk("post_rst", ALL, 0, 0, 0, 0, 0);

    // Saturation of the stall counter
    set_id(1, 0, 0, 2'b00, 8, 1, 15, 0);
    chk("sat_issue", ALL, 0, 0, 0, 0, 0);
    set_id(1, 8, 0, 2'b01, 0, 0, 0, 0);
    chk("sat_stall", ALL, 0, 0, 1, 1, 0);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    chk("sat_pre", EN_ST | EN_CN, 0, 0, 1, 1, 32'hFFFF_FFFD);
    chk("sat_m1", EN_ST | EN_CN, 0, 0, 1, 1, 32'hFFFF_FFFE);
    chk("sat_max", EN_ST | EN_CN, 0, 0, 1, 1, 32'hFFFF_FFFF);
    chk("sat_hold", EN_ST | EN_CN, 0, 0, 1, 1, 32'hFFFF_FFFF);

    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
